// File: rtl/sig_display.sv
// Signature display stage: captures completed signatures, tracks their stability and
// drives a four-digit multiplexed seven-segment display with HP signature characters.
module sig_display #(
    parameter int unsigned SCAN_DIV     = 1024,
    parameter int unsigned STABLE_COUNT = 2
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic [15:0] signature,
    input  logic        sig_valid,
    input  logic        hold,
    output logic [15:0] disp_word,
    output logic        unstable,
    output logic        valid,
    output logic [3:0]  digit_sel,
    output logic [6:0]  seg
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  STABLE_THR = 4'(STABLE_COUNT);

    logic [15:0] disp_q, disp_d;
    logic        unstable_q, unstable_d;
    logic        valid_q, valid_d;
    logic [3:0]  match_q, match_d;
    logic [15:0] scan_q, scan_d;
    logic [3:0]  sel_q, sel_d;
    logic [6:0]  seg_q, seg_d;
    logic        accept;
    logic [3:0]  nibble;
    logic [3:0]  match_inc;

    // Nibble to HP signature character (0-9 A C F H P U), segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_map(input logic [3:0] n);
        case (n)
            4'h0: seg_map = 7'h3F;
            4'h1: seg_map = 7'h06;
            4'h2: seg_map = 7'h5B;
            4'h3: seg_map = 7'h4F;
            4'h4: seg_map = 7'h66;
            4'h5: seg_map = 7'h6D;
            4'h6: seg_map = 7'h7D;
            4'h7: seg_map = 7'h07;
            4'h8: seg_map = 7'h7F;
            4'h9: seg_map = 7'h6F;
            4'hA: seg_map = 7'h77;
            4'hB: seg_map = 7'h39;
            4'hC: seg_map = 7'h71;
            4'hD: seg_map = 7'h76;
            4'hE: seg_map = 7'h73;
            default: seg_map = 7'h3E;
        endcase
    endfunction

    // sig_valid is a one-cycle strobe with no back-pressure: a strobe seen while hold
    // is high is discarded outright, never deferred.
    assign accept    = sig_valid && !hold;
    assign match_inc = (match_q == 4'd15) ? 4'd15 : match_q + 4'd1;

    always_comb begin
        disp_d     = disp_q;
        unstable_d = unstable_q;
        valid_d    = valid_q;
        match_d    = match_q;
        scan_d     = scan_q + 16'd1;
        sel_d      = sel_q;
        nibble     = 4'h0;
        seg_d      = 7'h00;

        if (accept) begin
            if (!valid_q) begin
                disp_d  = signature;
                valid_d = 1'b1;
                match_d = 4'd0;
            end else if (signature != disp_q) begin
                disp_d     = signature;
                unstable_d = 1'b1;
                match_d    = 4'd0;
            end else begin
                match_d = match_inc;
                if (match_inc == STABLE_THR) begin
                    unstable_d = 1'b0;
                end
            end
        end

        if (scan_q == SCAN_LAST) begin
            scan_d = 16'd0;
            sel_d  = {sel_q[0], sel_q[3:1]};
        end

        // Segments follow the next-state digit and word so they stay aligned with digit_sel.
        case (sel_d)
            4'b1000: nibble = disp_d[15:12];
            4'b0100: nibble = disp_d[11:8];
            4'b0010: nibble = disp_d[7:4];
            4'b0001: nibble = disp_d[3:0];
            default: nibble = 4'h0;
        endcase
        if (valid_d) begin
            seg_d = seg_map(nibble);
        end
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            disp_q     <= 16'h0000;
            unstable_q <= 1'b0;
            valid_q    <= 1'b0;
            match_q    <= 4'd0;
            scan_q     <= 16'd0;
            sel_q      <= 4'b1000;
            seg_q      <= 7'h00;
        end else begin
            disp_q     <= disp_d;
            unstable_q <= unstable_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            scan_q     <= scan_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign disp_word = disp_q;
    assign unstable  = unstable_q;
    assign valid     = valid_q;
    assign digit_sel = sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_sig_display.sv
// Directed bench for sig_display: capture/stability behaviour, character map,
// scan sequencing, hold, and asynchronous reset.
module tb_sig_display;

    localparam int unsigned SCAN_DIV_TB = 4;

    logic        clock;
    logic        reset_l;
    logic [15:0] signature;
    logic        sig_valid;
    logic        hold;
    logic [15:0] disp_word;
    logic        unstable;
    logic        valid;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;

    int vectors     = 0;
    int miscompares = 0;

    // Clock and reference scan position
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         m_cnt;
    logic [3:0] m_sel;
    always @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            m_cnt <= 0;
            m_sel <= 4'b1000;
        end else if (m_cnt == SCAN_DIV_TB - 1) begin
            m_cnt <= 0;
            m_sel <= {m_sel[0], m_sel[3:1]};
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    sig_display #(
        .SCAN_DIV    (SCAN_DIV_TB),
        .STABLE_COUNT(2)
    ) dut (
        .clock    (clock),
        .reset_l  (reset_l),
        .signature(signature),
        .sig_valid(sig_valid),
        .hold     (hold),
        .disp_word(disp_word),
        .unstable (unstable),
        .valid    (valid),
        .digit_sel(digit_sel),
        .seg      (seg)
    );

    // Hand-written character table
    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h39, 7'h71, 7'h76, 7'h73, 7'h3E};
        return tbl[n];
    endfunction

    function automatic logic [3:0] pick(input logic [15:0] w, input logic [3:0] sel);
        case (sel)
            4'b1000: return w[15:12];
            4'b0100: return w[11:8];
            4'b0010: return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [15:0] w);
        signature = w;
        sig_valid = 1'b1;
        tick();
        sig_valid = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] w, input logic u, input logic v);
        chk({tag, ".disp"}, disp_word, w);
        chk({tag, ".unstable"}, 16'(unstable), 16'(u));
        chk({tag, ".valid"}, 16'(valid), 16'(v));
    endtask

    // One full scan period: every cycle digit_sel and seg must match the selected nibble
    task automatic chk_scan(input string tag, input logic [15:0] w, input logic v);
        for (int i = 0; i < 4 * SCAN_DIV_TB; i++) begin
            chk({tag, ".sel"}, 16'(digit_sel), 16'(m_sel));
            chk({tag, ".seg"}, 16'(seg), v ? 16'(exp_seg(pick(w, m_sel))) : 16'h0000);
            tick();
        end
    endtask

    initial begin
        reset_l   = 1'b0;
        signature = 16'h0000;
        sig_valid = 1'b0;
        hold      = 1'b0;
        repeat (2) @(negedge clock);

        chk_state("reset", 16'h0000, 1'b0, 1'b0);
        chk("reset.sel", 16'(digit_sel), 16'h0008);
        chk("reset.seg", 16'(seg), 16'h0000);

        reset_l = 1'b1;
        // digit_sel leaves 1000 exactly at edge SCAN_DIV after release
        for (int i = 1; i < SCAN_DIV_TB; i++) begin
            tick();
            chk("first_dwell", 16'(digit_sel), 16'h0008);
        end
        tick();
        chk("first_rotate", 16'(digit_sel), 16'h0004);

        chk_scan("blank", 16'h0000, 1'b0);

        capture(16'h0000);
        chk_state("cap0", 16'h0000, 1'b0, 1'b1);
        chk_scan("scan0", 16'h0000, 1'b1);

        tick();
        tick();
        capture(16'hABCD);
        chk_state("capABCD", 16'hABCD, 1'b1, 1'b1);
        chk_scan("scanABCD", 16'hABCD, 1'b1);

        capture(16'h1E9F);
        chk_state("cap1E9F", 16'h1E9F, 1'b1, 1'b1);
        chk_scan("scan1E9F", 16'h1E9F, 1'b1);

        // Back-to-back strobes on consecutive clocks
        capture(16'h1234);
        chk_state("stab1", 16'h1234, 1'b1, 1'b1);
        capture(16'h1235);
        chk_state("stab2", 16'h1235, 1'b1, 1'b1);
        capture(16'h1235);
        chk_state("stab3", 16'h1235, 1'b1, 1'b1);
        capture(16'h1235);
        chk_state("stab4", 16'h1235, 1'b0, 1'b1);

        // Match counter saturation keeps unstable low
        for (int i = 0; i < 16; i++) begin
            capture(16'h1235);
        end
        chk_state("saturate", 16'h1235, 1'b0, 1'b1);

        // Hold drops strobes, including matching ones
        capture(16'h2222);
        chk_state("pre_hold", 16'h2222, 1'b1, 1'b1);
        hold = 1'b1;
        capture(16'hFFFF);
        chk_state("hold_ffff", 16'h2222, 1'b1, 1'b1);
        capture(16'h2222);
        capture(16'h2222);
        chk_state("hold_match", 16'h2222, 1'b1, 1'b1);
        chk_scan("scan_hold", 16'h2222, 1'b1);
        hold = 1'b0;
        capture(16'h2222);
        chk_state("unhold_m1", 16'h2222, 1'b1, 1'b1);
        capture(16'h2222);
        chk_state("unhold_m2", 16'h2222, 1'b0, 1'b1);
        capture(16'hFFFF);
        chk_state("unhold_ffff", 16'hFFFF, 1'b1, 1'b1);
        chk_scan("scanFFFF", 16'hFFFF, 1'b1);

        // Asynchronous reset between edges
        capture(16'h5A5A);
        chk_state("pre_reset", 16'h5A5A, 1'b1, 1'b1);
        #2 reset_l = 1'b0;
        #1;
        chk_state("async_rst", 16'h0000, 1'b0, 1'b0);
        chk("async_rst.sel", 16'(digit_sel), 16'h0008);
        chk("async_rst.seg", 16'(seg), 16'h0000);
        @(negedge clock);
        reset_l = 1'b1;
        capture(16'h1111);
        chk_state("post_rst_cap", 16'h1111, 1'b0, 1'b1);
        chk_scan("scan1111", 16'h1111, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sig_display.md
# sig_display

Display and stability stage directly downstream of `sigan`. Captures each completed 16-bit signature on a single-cycle strobe and compares it with the previous capture to drive the `unstable` indicator that `sigan` currently ties low. Renders the held signature as four HP signature characters (0-9, A, C, F, H, P, U) on a time-multiplexed, four-digit seven-segment display.

## Interface
- `SCAN_DIV`, default 1024: clocks each digit stays selected; legal range 2..65535.
- `STABLE_COUNT`, default 2: consecutive equal captures needed to clear `unstable`; legal range 1..15.
- `clock` in 1: single clock; all state is updated on the rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `signature` in 16: word from `sigan`; sampled only when `sig_valid` is high.
- `sig_valid` in 1: one-cycle strobe marking that `signature` holds a new completed measurement. The integration derives it from the falling edge of `sigan.gate`.
- `hold` in 1: when high, captures are ignored and the display and `unstable` stay frozen.
- `disp_word` out 16: the currently displayed (held) signature.
- `unstable` out 1: the last capture differed from its predecessor and stability has not yet been re-established.
- `valid` out 1: at least one capture has been accepted since reset.
- `digit_sel` out 4: one-hot, active-high digit enable. Bit 3 is the leftmost digit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-high.

## Operation
- Reset values: `disp_word`=0, `unstable`=0, `valid`=0, `digit_sel`=4'b1000, `seg`=0. Internal scan counter=0, match counter=0.
- Capture is accepted when `sig_valid`=1 and `hold`=0. `sig_valid` while `hold`=1 is dropped, with no state change and no queuing.
- First accepted capture after reset:
  - `disp_word`←`signature`, `valid`←1.
  - `unstable` stays 0; match counter←0.
- Subsequent accepted capture with `signature` ≠ `disp_word`:
  - `disp_word`←`signature`, `unstable`←1, match counter←0.
- Subsequent accepted capture with `signature` = `disp_word`:
  - Match counter increments, saturating at 15.
  - When the incremented value reaches `STABLE_COUNT`, `unstable`←0.
  - `disp_word` is unchanged.
- Scan sequencing:
  - The scan counter counts 0..`SCAN_DIV`-1 and then wraps.
  - On each wrap, `digit_sel` rotates right: 1000→0100→0010→0001→1000.
  - Scanning runs continuously, independent of `hold` and captures.
- Digit content: `digit_sel` bit 3 shows `disp_word[15:12]`, bit 2 shows [11:8], bit 1 shows [7:4], bit 0 shows [3:0].
- Character map, nibble → `seg` hex:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77 ("A"), B→39 ("C"), C→71 ("F")
  - D→76 ("H"), E→73 ("P"), F→3E ("U")
- Blanking: while `valid`=0, `seg`=0 on every digit.

## Timing
- Capture latency: a strobe sampled at edge N updates `disp_word`, `unstable` and `valid` at edge N, so they are visible from N+1.
- Back-to-back strobes on consecutive clocks are each processed. There is no minimum spacing.
- `digit_sel` and `seg` are both registered and change on the same edge. `seg` never shows one digit's pattern while a different digit is selected.
- A capture landing mid-scan changes `seg` for the currently selected digit on the next edge, without waiting for the scan to wrap.
- Scan period is 4×`SCAN_DIV` clocks. With the default, `digit_sel` leaves 1000 at edge 1024 after reset release.
- Reset asserted mid-operation forces all reset values immediately (asynchronous). Release is synchronous to the next `clock` edge.
- A `hold` change takes effect for a strobe in the same cycle.

## Test plan
- Reset, then `sig_valid` with 16'h0000 → `valid`=1, `unstable`=0, each digit `seg`=3F. Before the strobe, `seg`=0 for a full 4×`SCAN_DIV` scan.
- Capture 16'hABCD → digits left to right show `seg` 77, 39, 71, 76. Capture 16'h1E9F → `seg` 06, 73, 6F, 3E.
- `STABLE_COUNT`=2, captures 1234, 1235, 1235, 1235 → `unstable` = 0, 1, 1, 0 after each respective capture; `disp_word`=1235 at the end.
- `hold`=1 with capture 16'hFFFF → `disp_word`, `unstable` and `seg` unchanged. `hold`=0 with capture 16'hFFFF → `disp_word`=FFFF.
- `SCAN_DIV`=4 → `digit_sel` sequence 1000, 0100, 0010, 0001, 1000, each held exactly 4 clocks. `seg` matches the selected nibble on every cycle.
- Pull `reset_l` low between clock edges while `unstable`=1 and `disp_word`=5A5A → all outputs take their reset values before the next edge; a capture after release behaves as a first capture.
